// File: rtl/msk_rnd_pkg.sv
// ---------------------------------------------------------------------------
// msk_rnd_pkg
// Shared definitions for the masking randomness generator:
//   - LFSR geometry (31-bit Fibonacci, x^31 + x^28 + 1, taps at bits 30/27)
//   - substitute value used whenever an all-zero seed would lock the LFSR
//   - FSM state encoding for msk_rnd_prng
//   - helper functions for one LFSR step and zero-seed substitution
// ---------------------------------------------------------------------------
package msk_rnd_pkg;

  localparam int LFSR_W = 31;
  localparam int TAP_HI = 30;
  localparam int TAP_LO = 27;

  // The all-zero state is a fixed point of the LFSR, so it is never loaded.
  localparam logic [LFSR_W-1:0] LFSR_NZ = 31'h1;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  // One Fibonacci step: shift left, feedback bit enters at bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP_HI] ^ s[TAP_LO]};
  endfunction

  // Replace an all-zero seed by the nonzero substitute.
  function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] w);
    return (w == '0) ? LFSR_NZ : w;
  endfunction

endpackage

// File: rtl/msk_lfsr31.sv
// ---------------------------------------------------------------------------
// msk_lfsr31
// One 31-bit Fibonacci LFSR (x^31 + x^28 + 1).
// Ports:
//   clk        in   clock, state updates on rising edge
//   rst        in   synchronous active-high reset, state <= 31'h1
//   load       in   replace state with load_value (priority over step)
//   load_value in   31-bit value to load (caller guarantees nonzero)
//   step       in   advance the LFSR by one step
//   q          out  current LFSR state, straight from the register
// ---------------------------------------------------------------------------
module msk_lfsr31
  import msk_rnd_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_value,
  input  logic              step,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = load_value;
    end else if (step) begin
      lfsr_d = lfsr_step(lfsr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_NZ;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/msk_rnd_prng.sv
// ---------------------------------------------------------------------------
// msk_rnd_prng
// Fresh-randomness source for masked gadgets: NRND independent 31-bit LFSRs,
// one output bit each. After seeding, the LFSRs free-run for WARMUP steps
// before rnd is declared valid; in RUN they advance only when consumed.
// Parameters:
//   NRND    number of random bits per cycle (one LFSR per bit)
//   WARMUP  free-running steps between the last seed word and RUN (0 legal)
// Ports:
//   clk         in   clock
//   rst         in   synchronous active-high reset
//   seed_data   in   32-bit seed word, bits [30:0] used, bit 31 ignored
//   seed_valid  in   seed word present
//   seed_ready  out  seed word accepted this cycle (high in LOAD)
//   reseed      in   discard state and return to LOAD (no LFSR step)
//   rnd_en      in   consumer takes rnd; all LFSRs advance (RUN only)
//   rnd         out  bit i = MSB of LFSR i, register-driven
//   rnd_valid   out  rnd is fresh (high in RUN)
// ---------------------------------------------------------------------------
module msk_rnd_prng
  import msk_rnd_pkg::*;
#(
  parameter int NRND   = 2,
  parameter int WARMUP = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     seed_data,
  input  logic            seed_valid,
  output logic            seed_ready,
  input  logic            reseed,
  input  logic            rnd_en,
  output logic [NRND-1:0] rnd,
  output logic            rnd_valid
);

  localparam int CNT_W = ($clog2(WARMUP + 1) < 1) ? 1 : $clog2(WARMUP + 1);
  localparam int IDX_W = ($clog2(NRND) < 1) ? 1 : $clog2(NRND);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NRND - 1);
  // Counter value seen on the last warmup step; unused when WARMUP == 0.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WARMUP > 0) ? (WARMUP - 1) : 0);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;

  logic               load_en;
  logic               step_all;
  logic [LFSR_W-1:0]  seed_word;
  logic [NRND-1:0]    lfsr_load;
  logic [LFSR_W-1:0]  lfsr_q [NRND];

  // Bit 31 of the seed word carries no information.
  logic               unused_seed_msb;
  assign unused_seed_msb = seed_data[31];

  assign seed_word = seed_fix(seed_data[LFSR_W-1:0]);

  // -------------------------------------------------------------------------
  // Next-state logic. reseed overrides everything except rst, and never
  // steps or loads the LFSRs in the cycle it is seen.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    load_en  = 1'b0;
    step_all = 1'b0;

    if (reseed) begin
      state_d = ST_LOAD;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (seed_valid) begin
            load_en = 1'b1;
            if (idx_q == IDX_LAST) begin
              idx_d   = '0;
              cnt_d   = '0;
              state_d = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end

        ST_WARMUP: begin
          step_all = 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_RUN: begin
          step_all = rnd_en;
        end

        default: begin
          state_d = ST_LOAD;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOAD;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // LFSR bank: only the LFSR addressed by idx takes a seed word.
  // -------------------------------------------------------------------------
  for (genvar g = 0; g < NRND; g++) begin : g_lfsr
    assign lfsr_load[g] = load_en && (idx_q == IDX_W'(g));

    msk_lfsr31 u_lfsr (
      .clk        (clk),
      .rst        (rst),
      .load       (lfsr_load[g]),
      .load_value (seed_word),
      .step       (step_all),
      .q          (lfsr_q[g])
    );

    assign rnd[g] = lfsr_q[g][LFSR_W-1];
  end

  assign seed_ready = (state_q == ST_LOAD);
  assign rnd_valid  = (state_q == ST_RUN);

endmodule

// File: doc/msk_rnd_prng.md
MSK_RND_PRNG -- requirements
Module: msk_rnd_prng

Interface
REQ-001 Parameter NRND, default 2: number of fresh random bits delivered per cycle; one independent LFSR per bit.
REQ-002 Parameter WARMUP, default 64: free-running steps after seeding before output is released; 0 is legal.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 seed_data  input  32  seed word for the LFSR currently being loaded; bits [30:0] used, bit 31 ignored.
REQ-006 seed_valid  input  1  seed word present.
REQ-007 seed_ready  output  1  block accepts a seed word this cycle.
REQ-008 reseed  input  1  single-cycle request to discard all state and reload seeds.
REQ-009 rnd_en  input  1  consumer takes rnd this cycle; all LFSRs advance.
REQ-010 rnd  output  NRND  random bits, bit i = MSB (bit 30) of LFSR i; feeds the rnd port of masked gadgets.
REQ-011 rnd_valid  output  1  rnd is fresh and usable.

Function
REQ-012 Each LFSR SHALL be 31-bit Fibonacci, polynomial x^31+x^28+1: step = {s[29:0], s[30]^s[27]}.
REQ-013 FSM SHALL have states LOAD, WARMUP, RUN.
REQ-014 LOAD: seed_ready=1; on seed_valid&seed_ready, LFSR[idx] <= seed_data[30:0] and idx increments, idx running 0..NRND-1.
REQ-015 A seed word with bits [30:0] all zero SHALL load 31'h1 instead.
REQ-016 On acceptance of word NRND-1, next state SHALL be WARMUP with counter cleared, or RUN if WARMUP=0.
REQ-017 WARMUP: all LFSRs step every cycle, counter increments; after exactly WARMUP steps, next state SHALL be RUN.
REQ-018 RUN: rnd_valid=1; LFSRs step only in cycles with rnd_en=1; rnd_en=0 holds state, so the same rnd value persists.
REQ-019 rnd_valid SHALL be 0 in LOAD and WARMUP; rnd_en SHALL be ignored outside RUN.
REQ-020 reseed=1 in any state SHALL return to LOAD with idx=0 next cycle, without stepping LFSRs; it has priority over rnd_en and seed handshake in the same cycle.
REQ-021 rnd SHALL be driven directly from LFSR registers, with no combinational path from inputs.
REQ-022 Warmup counter width SHALL be $clog2(WARMUP+1), minimum 1; idx width $clog2(NRND), minimum 1.

Reset
REQ-023 rst=1 SHALL set state LOAD, idx=0, counter=0, every LFSR=31'h1, rnd_valid=0, seed_ready=1 from the next cycle.
REQ-024 rst SHALL take priority over reseed, seed handshake and rnd_en; reset mid-load discards already-accepted words.

Structure
REQ-025 Package msk_rnd_pkg SHALL hold LFSR width (31), tap positions (30, 27), nonzero substitute (31'h1) and the FSM state enum.
REQ-026 Sub-module msk_lfsr31 SHALL implement one LFSR with load, load_value, step and q ports; msk_rnd_prng instantiates NRND copies.

Verification
REQ-027 Load/run, NRND=2, WARMUP=0, seeds 0x00000001 and 0x40000000:
- rnd_valid=1 the cycle after the 2nd handshake.
- rnd=2'b10.
- After 30 rnd_en cycles, rnd[0]=1.
REQ-028 Zero seed, NRND=2, WARMUP=0, seeds 0x00000000 and 0x80000000:
- Both LFSRs hold 31'h1.
- rnd=2'b00 for 30 rnd_en cycles.
- Both bits go 1 on the 30th step.
REQ-029 Warmup, WARMUP=64:
- rnd_valid rises exactly 64 cycles after the last seed handshake.
- rnd matches the golden model stepped 64 times.
REQ-030 Stall, RUN with rnd_en=0 for 10 cycles: rnd constant; resumes the golden sequence without skipped steps.
REQ-031 Reseed with rnd_en=1 in the same cycle:
- No step.
- rnd_valid=0 and seed_ready=1 next cycle.
- A new seed sequence reproduces REQ-027 exactly.
REQ-032 rst asserted after 1 of 2 seed words: idx returns to 0; LFSRs return to 31'h1; the full 2-word load is required again.
